text_overlay_reader: RTL
========================

TEXT_OVERLAY_READER -- requirements
Module: text_overlay_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- COLS, 80, text columns per row.
- ROWS, 30, text rows per screen.
- BLINK_FRAMES, 32, frames per blink half-period; used only when TEXT_BLINK_EN is defined.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock; the only clock.
- rst, in, 1, reset; asynchronous, active-low.
- hcount, in, 10, current pixel x.
- vcount, in, 10, current pixel y.
- active_in, in, 1, visible-area flag.
- hsync_in, in, 1, horizontal sync.
- vsync_in, in, 1, vertical sync.
- text_off, in, 1, blanks all text.
- char_addr, out, 12, character RAM read address.
- char_data, in, 8, character RAM read data; synchronous, 1-cycle latency.
- font_addr, out, 12, font ROM address, {code[7:0], glyph_row[3:0]}.
- font_data, in, 8, font ROM row bits, MSB is leftmost; 1-cycle latency.
- text_pixel, out, 1, text foreground pixel.
- active_out, out, 1, active_in delayed to align with text_pixel.
- hsync_out, out, 1, hsync_in delayed to align with text_pixel.
- vsync_out, out, 1, vsync_in delayed to align with text_pixel.

Function
REQ-003 The block SHALL be the read side of the 80x30 character RAM:
- Glyph cell is 8x16 pixels.
- Character RAM address = (vcount>>4)*COLS + (hcount>>3).
- Address range is 0..COLS*ROWS-1 (0..2399).

REQ-004 The pipeline SHALL have these stages, with inputs presented in cycle N:
- N+1: char_addr registered.
- N+2: char_data sampled; font_addr registered as {char_data, vcount[3:0] delayed by 2}.
- N+3: font_data valid.
- N+4: text_pixel registered.

REQ-005 text_pixel SHALL equal font_data[7 - hcount[2:0]], using hcount[2:0] delayed by 3 cycles.

REQ-006 Total latency from inputs to text_pixel SHALL be exactly 4 cycles; active_out, hsync_out and vsync_out SHALL each be delayed by exactly 4 cycles.

REQ-007 char_addr SHALL hold its previous value when hcount>=640, vcount>=480 or active_in=0; the delayed active flag SHALL force text_pixel=0 for that pixel.

REQ-008 Character code 0 SHALL render blank regardless of font_data, because a cleared screen is all zeros.

REQ-009 text_off=1 SHALL force text_pixel=0 from the cycle after it is sampled; the pipeline and sync delays SHALL continue unaffected.

REQ-010 Address arithmetic SHALL use 12 bits with no wrap.
- The maximum address 29*80+79 = 2399 SHALL be reachable.
- No address above 2399 SHALL ever be issued.

REQ-011 The address computation SHALL use no divider; the multiply by 80 is (row<<6)+(row<<4).

Reset
REQ-012 While rst=0, the following SHALL be 0: all pipeline registers, char_addr, font_addr, text_pixel, active_out, hsync_out and vsync_out.

REQ-013 Reset asserted mid-line SHALL clear the pipeline immediately.
- After release, the first valid text_pixel SHALL appear 4 cycles after the first active input.
- No stale glyph bits SHALL be output.

REQ-014 The blink frame counter and blink phase (REQ-015) SHALL reset to 0.

Configuration
REQ-015 With TEXT_BLINK_EN defined, the block SHALL implement attribute blink.
- A frame counter increments on each rising edge of vsync_in.
- Blink phase toggles each time the counter reaches BLINK_FRAMES-1; the counter then returns to 0.
- Characters with char_data[7]=1 render inverted (text_pixel = ~glyph bit) while phase=1.
- Only codes 0x01..0x7F index glyphs, i.e. font_addr uses {1'b0, char_data[6:0], row}.
- A phase toggle SHALL take effect only at the start of a frame, never mid-frame.

REQ-016 Without TEXT_BLINK_EN, no frame counter or phase logic SHALL exist, and all 8 bits of char_data SHALL index the font.

Verification
REQ-017 Reset alignment: hold rst=0 for 5 cycles, release, then drive active_in=1 at hcount=0, vcount=0 -> all outputs are 0 during reset; active_out rises exactly 4 cycles after active_in.

REQ-018 Addressing: hcount=639, vcount=479 -> char_addr=2399 one cycle later; hcount=8, vcount=16 -> char_addr=81.

REQ-019 Glyph bits: char RAM[0]=0x41, font row 0 of 0x41 = 0x18, sweep hcount 0..7 at vcount=0 -> text_pixel sequence 0,0,0,1,1,0,0,0, each appearing 4 cycles after its hcount.

REQ-020 Blank cases: code 0 with font_data=0xFF -> text_pixel=0; text_off=1 on a row of 0x41 glyphs -> text_pixel=0 while hsync_out/vsync_out timing is unchanged.

REQ-021 Blanking region: hcount=700 with active_in=0 -> char_addr unchanged from the last active pixel and text_pixel=0.

REQ-022 Blink (TEXT_BLINK_EN defined, BLINK_FRAMES=2): code 0xC1 -> normal glyph in frames 0-1, inverted glyph in frames 2-3, normal again in frame 4.

Source files
------------

// File: rtl/text_overlay_reader.sv
// Read side of the character RAM: turns pixel coordinates into a 1-bit text foreground stream, 4 cycles late.
// Optional attribute blink (bit 7 of the code inverts the glyph on alternate blink phases) with `define TEXT_BLINK_EN.
module text_overlay_reader #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        text_off,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        text_pixel,
    output logic        active_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int          STAGES = 4;
    localparam logic [11:0] COLS_L = 12'(COLS);
    localparam logic [11:0] ROWS_L = 12'(ROWS);

    logic [11:0]        row_w, col_w, row_base, addr_next;
    logic               in_vis;
    logic [STAGES-1:1]  vld_pipe;
    logic [STAGES:1]    act_pipe, hs_pipe, vs_pipe;
    logic [2:0]         hc1, hc2, hc3;
    logic [3:0]         vc1;
    logic               blank2, blank3, inv2, inv3;
    logic [7:0]         font_q;
    logic [7:0]         glyph_code;
    logic               inv_next;

    assign row_w = {6'd0, vcount[9:4]};
    assign col_w = {5'd0, hcount[9:3]};

    // 80 columns is the native mode; keep it to two shifted adds.
    generate
        if (COLS == 80) begin : g_mul80
            assign row_base = (row_w << 6) + (row_w << 4);
        end else begin : g_mul
            assign row_base = row_w * COLS_L;
        end
    endgenerate

    assign addr_next = row_base + col_w;

    // Only in-screen cells issue an address, so nothing above COLS*ROWS-1 ever leaves the block.
    assign in_vis = active_in && (hcount < 10'd640) && (vcount < 10'd480) &&
                    (row_w < ROWS_L) && (col_w < COLS_L);

`ifdef TEXT_BLINK_EN
    localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic             blink_phase;
    logic             vs_prev;

    // Phase only flips on the vsync rising edge, so a visible frame never changes mid-way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            vs_prev     <= 1'b0;
        end else begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign glyph_code = {1'b0, char_data[6:0]};
    assign inv_next   = char_data[7] & blink_phase;
`else
    assign glyph_code = char_data;
    assign inv_next   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_addr  <= '0;
            font_addr  <= '0;
            text_pixel <= 1'b0;
            vld_pipe   <= '0;
            act_pipe   <= '0;
            hs_pipe    <= '0;
            vs_pipe    <= '0;
            hc1        <= '0;
            hc2        <= '0;
            hc3        <= '0;
            vc1        <= '0;
            blank2     <= 1'b0;
            blank3     <= 1'b0;
            inv2       <= 1'b0;
            inv3       <= 1'b0;
            font_q     <= '0;
        end else begin
            if (in_vis)
                char_addr <= addr_next;
            vld_pipe <= {vld_pipe[STAGES-2:1], in_vis};
            act_pipe <= {act_pipe[STAGES-1:1], active_in};
            hs_pipe  <= {hs_pipe[STAGES-1:1], hsync_in};
            vs_pipe  <= {vs_pipe[STAGES-1:1], vsync_in};
            hc1      <= hcount[2:0];
            hc2      <= hc1;
            hc3      <= hc2;
            vc1      <= vcount[3:0];
            // Code 0 is a cleared cell and must stay blank whatever the font holds.
            font_addr <= {glyph_code, vc1};
            blank2    <= (char_data == 8'h00);
            inv2      <= inv_next;
            blank3    <= blank2;
            inv3      <= inv2;
            font_q    <= font_data;
            text_pixel <= vld_pipe[STAGES-1] & ~blank3 & ~text_off & (font_q[~hc3] ^ inv3);
        end
    end

    assign active_out = act_pipe[STAGES];
    assign hsync_out  = hs_pipe[STAGES];
    assign vsync_out  = vs_pipe[STAGES];

endmodule
